// File: rtl/serial_pkg.sv
// Shared types and register map for the serial receiver.
// The CPU side sees two words: DATA at 0x0 and STATUS at 0x4.
package serial_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [31:0] REG_DATA   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam int          REG_SEL_BIT = 2;

  localparam int ST_NEMPTY    = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_FERR      = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int DATA_VALID_BIT = 31;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop and a push in the same cycle
// both take effect even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q  = '0;
  logic [AW-1:0]    rd_q  = '0;
  logic [NW-1:0]    cnt_q = '0;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_N);
  assign count   = cnt_q;
  assign dout    = mem[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + NW'(1);
        2'b01:   cnt_q <= cnt_q - NW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  a_count_bounded: assert property (@(posedge clk) cnt_q <= DEPTH_N);

endmodule

// File: rtl/serialrx.sv
// UART receiver with a small receive FIFO behind a pipelined Wishbone slave.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | timing half a bit to re-check the start bit
//   RX_DATA  | sampling data bits mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; push or flag framing error
module serialrx
  import serial_pkg::*;
#(
  parameter int DIVIDE = 2,
  parameter int FRAME  = 8,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        irq
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int IW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int NW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(DIVIDE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(DIVIDE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(FRAME - 1);

  logic            rx_meta = 1'b1;
  logic            rx_s    = 1'b1;
  rx_state_t       state_q = RX_IDLE;
  rx_state_t       state_d;
  logic [CW-1:0]   cnt_q   = '0;
  logic [CW-1:0]   cnt_d;
  logic [IW-1:0]   idx_q   = '0;
  logic [IW-1:0]   idx_d;
  logic [FRAME-1:0] shreg_q = '0;
  logic [FRAME-1:0] shreg_d;
  logic            char_push;
  logic            frame_err;

  logic            ovr_q   = 1'b0;
  logic            ferr_q  = 1'b0;
  logic            ack_q   = 1'b0;
  logic [31:0]     data_q  = '0;
  logic [31:0]     rd_val;

  logic            accept;
  logic            is_status;
  logic            rd_pop;
  logic            status_wr;
  logic            ovr_set;

  logic [FRAME-1:0] fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [NW-1:0]   fifo_count;

  logic            unused_ok;
  assign unused_ok = ^{wb_addr[31:3], wb_addr[1:0], wb_data_w[31:4], wb_data_w[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    char_push = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[FRAME-1:1]};
          if (idx_q == LAST_BIT) begin
            idx_d   = '0;
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          char_push = rx_s;
          frame_err = !rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH(FRAME),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (char_push),
    .pop  (rd_pop),
    .din  (shreg_q),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign accept    = wb_stb && wb_cyc;
  assign is_status = wb_addr[REG_SEL_BIT];
  assign rd_pop    = accept && !wb_we && !is_status && !fifo_empty;
  assign status_wr = accept && wb_we && is_status;
  assign ovr_set   = char_push && fifo_full && !rd_pop;

  always_comb begin
    rd_val = '0;
    if (is_status) begin
      rd_val[ST_NEMPTY]                = !fifo_empty;
      rd_val[ST_FULL]                  = fifo_full;
      rd_val[ST_OVR]                   = ovr_q;
      rd_val[ST_FERR]                  = ferr_q;
      rd_val[ST_COUNT_LSB +: NW]       = fifo_count;
    end else if (!fifo_empty) begin
      rd_val[FRAME-1:0]                = fifo_head;
      rd_val[DATA_VALID_BIT]           = 1'b1;
    end
  end

  // Setting a flag in the same cycle as a write-1-to-clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (ovr_set)                               ovr_q <= 1'b1;
      else if (status_wr && wb_data_w[ST_OVR])   ovr_q <= 1'b0;
      if (frame_err)                             ferr_q <= 1'b1;
      else if (status_wr && wb_data_w[ST_FERR])  ferr_q <= 1'b0;
      ack_q <= accept;
      if (accept && !wb_we) data_q <= rd_val;
    end
  end

  assign wb_ack    = ack_q && wb_cyc;
  assign wb_stall  = 1'b0;
  assign wb_data_r = data_q;
  assign irq       = !fifo_empty;

  logic [31:0] n_stb_q = '0;
  logic [31:0] n_ack_q = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_stb_q <= '0;
      n_ack_q <= '0;
    end else begin
      if (accept) n_stb_q <= n_stb_q + 32'd1;
      if (wb_ack) n_ack_q <= n_ack_q + 32'd1;
    end
  end

  a_ack_le_stb: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, n_ack_q} + 33'(wb_ack)) <= {1'b0, n_stb_q});
  a_no_ack_without_cyc: assert property (@(posedge clk) !wb_cyc |-> !wb_ack);

endmodule
